// File: rtl/popcount_window_accumulator_if.sv
// Handshake bundle between the popcount stage, the window accumulator and the
// downstream display/IO register.
interface popcount_window_accumulator_if #(
  parameter int SUM_W = 7,
  parameter int IDX_W = 6
);
  logic             start;
  logic [4:0]       cnt_onehot;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] sum;
  logic [2:0]       peak;
  logic             onehot_err;
  logic [IDX_W-1:0] sample_idx;
  logic             busy;

  modport master (
    output start, cnt_onehot, in_valid, out_ready,
    input  in_ready, out_valid, sum, peak, onehot_err, sample_idx, busy
  );

  modport slave (
    input  start, cnt_onehot, in_valid, out_ready,
    output in_ready, out_valid, sum, peak, onehot_err, sample_idx, busy
  );
endinterface

// File: rtl/popcount_window_accumulator.sv
// Sums WINDOW one-hot popcount samples, tracks the peak count and flags
// malformed samples, then offers the result on a valid/ready handshake.
module popcount_window_accumulator #(
  parameter int WINDOW = 16,
  parameter int SUM_W  = 7,
  parameter int IDX_W  = 6
) (
  input  logic clk,
  input  logic rst_n,  // active-high despite the name
  popcount_window_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W:0] WIN_CNT = (IDX_W + 1)'(WINDOW);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [2:0]       peak_q, peak_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [2:0]       weight;
  logic             malformed;
  logic             accept;
  logic [IDX_W:0]   idx_inc;
  logic             last_sample;

  // Anything other than exactly one set bit decodes to weight 0 and is flagged.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    weight    = 3'd0;
    malformed = 1'b0;
    case (bus.cnt_onehot)
      5'b00001: weight = 3'd0;
      5'b00010: weight = 3'd1;
      5'b00100: weight = 3'd2;
      5'b01000: weight = 3'd3;
      5'b10000: weight = 3'd4;
      default:  malformed = 1'b1;
    endcase
  end

  assign accept      = bus.in_valid && (state_q == ST_ACCUM);
  assign idx_inc     = {1'b0, idx_q} + (IDX_W + 1)'(1);
  assign last_sample = (idx_inc == WIN_CNT);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    peak_d  = peak_q;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ACCUM;
          sum_d   = '0;
          peak_d  = '0;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          sum_d  = sum_q + SUM_W'(weight);
          peak_d = (weight > peak_q) ? weight : peak_q;
          err_d  = err_q | malformed;
          idx_d  = idx_inc[IDX_W-1:0];
          if (last_sample) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Results stay frozen until the consumer takes them; a start in the
        // same cycle opens the next window without passing through IDLE.
        if (bus.out_ready) begin
          if (bus.start) begin
            state_d = ST_ACCUM;
            sum_d   = '0;
            peak_d  = '0;
            err_d   = 1'b0;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      peak_q  <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q <= state_d;
      sum_q   <= sum_d;
      peak_q  <= peak_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake flags decode straight from the state register: no input-to-output path.
  assign bus.in_ready   = (state_q == ST_ACCUM);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.sum        = sum_q;
  assign bus.peak       = peak_q;
  assign bus.onehot_err = err_q;
  assign bus.sample_idx = idx_q;

endmodule

// File: tb/tb_popcount_window_accumulator.sv
// Self-checking bench: directed table, hand sequences for handshake corners,
// and randomized windows against a queue-free arithmetic reference model.
module tb_popcount_window_accumulator;
  localparam int WINDOW = 16;
  localparam int SUM_W  = 7;
  localparam int IDX_W  = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  popcount_window_accumulator_if #(.SUM_W(SUM_W), .IDX_W(IDX_W)) bus ();

  popcount_window_accumulator #(
    .WINDOW(WINDOW), .SUM_W(SUM_W), .IDX_W(IDX_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0] cnt;
    int         e_sum;
    int         e_peak;
    int         e_err;
    int         e_idx;
  } vec_t;

  vec_t tbl[16];
  int   checks   = 0;
  int   failures = 0;
  int   m_sum, m_peak, m_err, m_idx;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: weight is the position of the single set bit, else 0.
  function automatic int ref_weight(input logic [4:0] c);
    int w;
    w = 0;
    if ($countones(c) == 1)
      for (int i = 0; i < 5; i++) if (c[i]) w = i;
    return w;
  endfunction

  task automatic model_clear();
    m_sum = 0; m_peak = 0; m_err = 0; m_idx = 0;
  endtask

  task automatic chk_state(input string tag, input int e_rdy, input int e_vld, input int e_busy);
    check({tag, "_in_ready"},  int'(bus.in_ready),  e_rdy);
    check({tag, "_out_valid"}, int'(bus.out_valid), e_vld);
    check({tag, "_busy"},      int'(bus.busy),      e_busy);
  endtask

  task automatic chk_acc(input string tag, input int e_sum, input int e_peak,
                         input int e_err, input int e_idx);
    check({tag, "_sum"},  int'(bus.sum),        e_sum);
    check({tag, "_peak"}, int'(bus.peak),       e_peak);
    check({tag, "_err"},  int'(bus.onehot_err), e_err);
    check({tag, "_idx"},  int'(bus.sample_idx), e_idx);
  endtask

  task automatic chk_all_zero(input string tag);
    check(tag, int'({bus.in_ready, bus.out_valid, bus.busy, bus.onehot_err,
                     bus.peak, bus.sum, bus.sample_idx}), 0);
  endtask

  task automatic start_window();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_state("start", 1, 0, 1);
    chk_acc("start", 0, 0, 0, 0);
    model_clear();
  endtask

  // Offer one sample once in_ready is seen, update the model and compare running values.
  task automatic feed(input logic [4:0] cnt, input int gap, input bit st);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("feed_ready_timeout", 0, 1);
      return;
    end
    bus.cnt_onehot = cnt;
    bus.in_valid   = 1'b1;
    bus.start      = st;
    step();
    bus.in_valid   = 1'b0;
    bus.start      = 1'b0;
    bus.cnt_onehot = 5'($urandom);
    m_sum  += ref_weight(cnt);
    if (ref_weight(cnt) > m_peak) m_peak = ref_weight(cnt);
    if ($countones(cnt) != 1) m_err = 1;
    m_idx++;
    chk_acc("run", m_sum, m_peak, m_err, m_idx);
    check("run_out_valid", int'(bus.out_valid), (m_idx == WINDOW) ? 1 : 0);
    repeat (gap) step();
  endtask

  task automatic release_window(input bit btb);
    bus.out_ready = 1'b1;
    bus.start     = btb;
    step();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    if (btb) begin
      chk_state("btb", 1, 0, 1);
      chk_acc("btb", 0, 0, 0, 0);
      model_clear();
    end else begin
      chk_state("release", 0, 0, 0);
      chk_acc("release_hold", m_sum, m_peak, m_err, m_idx);
    end
  endtask

  initial begin
    tbl[0]  = '{5'b00001,  0, 0, 0,  1};
    tbl[1]  = '{5'b00010,  1, 1, 0,  2};
    tbl[2]  = '{5'b01000,  4, 3, 0,  3};
    tbl[3]  = '{5'b00100,  6, 3, 0,  4};
    tbl[4]  = '{5'b00110,  6, 3, 1,  5};
    tbl[5]  = '{5'b10000, 10, 4, 1,  6};
    tbl[6]  = '{5'b00000, 10, 4, 1,  7};
    tbl[7]  = '{5'b00010, 11, 4, 1,  8};
    tbl[8]  = '{5'b11111, 11, 4, 1,  9};
    tbl[9]  = '{5'b01000, 14, 4, 1, 10};
    tbl[10] = '{5'b10001, 14, 4, 1, 11};
    tbl[11] = '{5'b00100, 16, 4, 1, 12};
    tbl[12] = '{5'b00001, 16, 4, 1, 13};
    tbl[13] = '{5'b10000, 20, 4, 1, 14};
    tbl[14] = '{5'b00010, 21, 4, 1, 15};
    tbl[15] = '{5'b01000, 24, 4, 1, 16};

    rst_n          = 1'b1;
    bus.start      = 1'b0;
    bus.cnt_onehot = 5'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    model_clear();

    // Reset, then idle with start low; stray in_valid must be dropped.
    repeat (2) begin
      step();
      chk_all_zero("reset_outputs");
    end
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid   = i[0];
      bus.cnt_onehot = 5'b10000;
      step();
      chk_all_zero("idle_outputs");
    end
    bus.in_valid = 1'b0;

    // Full window of 4s.
    start_window();
    for (int k = 0; k < WINDOW; k++) feed(5'b10000, 0, 1'b0);
    chk_state("full4_done", 0, 1, 1);
    chk_acc("full4", 64, 4, 0, 16);
    release_window(1'b0);

    // Directed table: every legal code plus several malformed ones.
    start_window();
    for (int i = 0; i < 16; i++) begin
      feed(tbl[i].cnt, 0, 1'b0);
      chk_acc("tbl", tbl[i].e_sum, tbl[i].e_peak, tbl[i].e_err, tbl[i].e_idx);
    end
    chk_state("tbl_done", 0, 1, 1);
    release_window(1'b0);

    // Counts 1,2,3,4,0 repeated with in_valid every other cycle, then backpressure.
    start_window();
    for (int k = 0; k < WINDOW; k++) feed(5'(1 << ((k + 1) % 5)), 1, 1'b0);
    chk_acc("mixed", 31, 4, 0, 16);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid   = 1'b1;
      bus.cnt_onehot = 5'b10000;
      bus.start      = i[0];
      step();
      chk_state("mixed_hold", 0, 1, 1);
      chk_acc("mixed_hold", 31, 4, 0, 16);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    release_window(1'b0);

    // Malformed samples, then a back-to-back window.
    start_window();
    for (int k = 0; k < WINDOW; k++)
      feed((k == 1) ? 5'b00110 : (k == 3) ? 5'b00000 : 5'b00100, 0, 1'b0);
    chk_acc("malformed", 28, 2, 1, 16);
    release_window(1'b1);
    for (int k = 0; k < WINDOW; k++) feed(5'b01000, 0, 1'b0);
    chk_acc("second_window", 48, 3, 0, 16);
    release_window(1'b0);

    // Randomized windows against the reference model.
    begin
      bit btb;
      btb = 1'b0;
      for (int w = 0; w < 20; w++) begin
        logic [4:0] c;
        if (!btb) start_window();
        for (int k = 0; k < WINDOW; k++) begin
          if ($urandom_range(0, 4) == 0) c = 5'($urandom);
          else c = 5'(1 << $urandom_range(0, 4));
          feed(c, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        repeat ($urandom_range(0, 3)) begin
          step();
          check("rand_hold_valid", int'(bus.out_valid), 1);
          check("rand_hold_sum", int'(bus.sum), m_sum);
        end
        btb = 1'($urandom_range(0, 1));
        release_window(btb);
      end
      if (btb) begin
        for (int k = 0; k < WINDOW; k++) feed(5'b00010, 0, 1'b0);
        release_window(1'b0);
      end
    end

    // Reset asserted between clock edges in the middle of a window.
    start_window();
    for (int k = 0; k < 7; k++) feed(5'b01000, 0, 1'b0);
    chk_acc("pre_reset", 21, 3, 0, 7);
    #2;
    rst_n = 1'b1;
    #1;
    chk_all_zero("async_reset");
    step();
    rst_n = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        bus.in_valid   = i[0];
        bus.cnt_onehot = 5'b10000;
        bus.out_ready  = 1'($urandom_range(0, 1));
        step();
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== '0) bad++;
      end
      check("post_reset_quiet", bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
